// File: rtl/traffic_intersection.sv
// Two-approach intersection controller: main approach A, side approach B with
// latched side-street demand, all-red clearance and a maintenance flash mode.
module traffic_intersection #(
    parameter int CNT_W    = 8,
    parameter int T_GREEN  = 20,
    parameter int T_YELLOW = 4,
    parameter int T_ALLRED = 2,
    parameter int T_FLASH  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       flash,
    input  logic       req_b,
    output logic       a_red,
    output logic       a_yellow,
    output logic       a_green,
    output logic       b_red,
    output logic       b_yellow,
    output logic       b_green,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        A_GRN = 3'd0,
        A_YEL = 3'd1,
        AR_AB = 3'd2,
        B_GRN = 3'd3,
        B_YEL = 3'd4,
        AR_BA = 3'd5,
        FLASH = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(T_FLASH - 1);

    // Lamp vector order: {a_red, a_yellow, a_green, b_red, b_yellow, b_green}.
    // Unknown codes fall back to all-red.
    function automatic logic [5:0] lamp_decode(input state_t st, input logic fon);
        logic [5:0] lamps;
        case (st)
            A_GRN:        lamps = 6'b001_100;
            A_YEL:        lamps = 6'b010_100;
            AR_AB, AR_BA: lamps = 6'b100_100;
            B_GRN:        lamps = 6'b100_001;
            B_YEL:        lamps = 6'b100_010;
            FLASH:        lamps = {1'b0, fon, 1'b0, 1'b0, fon, 1'b0};
            default:      lamps = 6'b100_100;
        endcase
        return lamps;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    state_t           dwell_to_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] dwell_last_s;
    logic             req_pend_r;
    logic             req_pend_nxt_s;
    logic             flash_on_r;
    logic             flash_on_nxt_s;
    logic [5:0]       lamps_r;
    logic [2:0]       phase_r;

    // Dwell length and successor for each fixed-dwell state.
    always_comb begin
        dwell_last_s = ALLRED_LAST;
        dwell_to_s   = AR_BA;
        case (state_r)
            A_GRN: begin
                dwell_last_s = GREEN_LAST;
                dwell_to_s   = A_YEL;
            end
            A_YEL: begin
                dwell_last_s = YELLOW_LAST;
                dwell_to_s   = AR_AB;
            end
            AR_AB: begin
                dwell_last_s = ALLRED_LAST;
                dwell_to_s   = B_GRN;
            end
            B_GRN: begin
                dwell_last_s = GREEN_LAST;
                dwell_to_s   = B_YEL;
            end
            B_YEL: begin
                dwell_last_s = YELLOW_LAST;
                dwell_to_s   = AR_BA;
            end
            AR_BA: begin
                dwell_last_s = ALLRED_LAST;
                dwell_to_s   = A_GRN;
            end
            default: begin
                dwell_last_s = ALLRED_LAST;
                dwell_to_s   = AR_BA;
            end
        endcase
    end

    // Next state, dwell counter and flash phase; flash overrides dwell timing.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        flash_on_nxt_s = flash_on_r;
        if (state_r == FLASH) begin
            if (!flash) begin
                state_nxt_s    = AR_BA;
                cnt_nxt_s      = CNT_ZERO;
                flash_on_nxt_s = 1'b0;
            end else if (cnt_r == FLASH_LAST) begin
                cnt_nxt_s      = CNT_ZERO;
                flash_on_nxt_s = ~flash_on_r;
            end else begin
                cnt_nxt_s = cnt_r + CNT_ONE;
            end
        end else if (flash) begin
            state_nxt_s    = FLASH;
            cnt_nxt_s      = CNT_ZERO;
            flash_on_nxt_s = 1'b1;
        end else if (enable) begin
            if (cnt_r != dwell_last_s) begin
                cnt_nxt_s = cnt_r + CNT_ONE;
            end else if (state_r != A_GRN || req_pend_r || req_b) begin
                // A green saturates here until side-street demand appears
                state_nxt_s = dwell_to_s;
                cnt_nxt_s   = CNT_ZERO;
            end else begin
                cnt_nxt_s = cnt_r;
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Demand latch; clearing on B green entry beats a coincident request.
    always_comb begin
        if (state_nxt_s == B_GRN && state_r != B_GRN) begin
            req_pend_nxt_s = 1'b0;
        end else begin
            req_pend_nxt_s = req_pend_r | req_b;
        end
    end

    // State, counter and registered outputs, all decoded from next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= AR_BA;
            cnt_r      <= CNT_ZERO;
            req_pend_r <= 1'b0;
            flash_on_r <= 1'b0;
            lamps_r    <= 6'b100_100;
            phase_r    <= 3'd5;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            req_pend_r <= req_pend_nxt_s;
            flash_on_r <= flash_on_nxt_s;
            lamps_r    <= lamp_decode(state_nxt_s, flash_on_nxt_s);
            phase_r    <= state_nxt_s;
        end
    end

    assign {a_red, a_yellow, a_green, b_red, b_yellow, b_green} = lamps_r;
    assign phase = phase_r;

endmodule

// File: tb/tb_traffic_intersection.sv
// Directed scoreboard bench for traffic_intersection with a randomised safety sweep.
module tb_traffic_intersection;

    logic       clk = 1'b0;
    logic       reset, enable, flash, req_b;
    logic       a_red, a_yellow, a_green, b_red, b_yellow, b_green;
    logic [2:0] phase;

    always #5 clk = ~clk;

    traffic_intersection dut (
        .clk(clk), .reset(reset), .enable(enable), .flash(flash), .req_b(req_b),
        .a_red(a_red), .a_yellow(a_yellow), .a_green(a_green),
        .b_red(b_red), .b_yellow(b_yellow), .b_green(b_green),
        .phase(phase)
    );

    typedef struct {
        string      tag;
        logic [2:0] ph;
        logic [5:0] lamps;
    } exp_t;

    exp_t sb_q[$];
    int   check_cnt = 0;
    int   pass_cnt  = 0;
    int   fail_cnt  = 0;

    function automatic logic [5:0] exp_lamps(input logic [2:0] ph, input logic fon);
        case (ph)
            3'd0:       return 6'b001_100;
            3'd1:       return 6'b010_100;
            3'd2, 3'd5: return 6'b100_100;
            3'd3:       return 6'b100_001;
            3'd4:       return 6'b100_010;
            3'd6:       return {1'b0, fon, 1'b0, 1'b0, fon, 1'b0};
            default:    return 6'b000_000;
        endcase
    endfunction

    // Timeline with one req_b pulse at cycle 5 and s disabled cycles inside B green.
    function automatic logic [2:0] demand_phase(input int c, input int s);
        if (c < 2)           return 3'd5;
        else if (c < 22)     return 3'd0;
        else if (c < 26)     return 3'd1;
        else if (c < 28)     return 3'd2;
        else if (c < 48 + s) return 3'd3;
        else if (c < 52 + s) return 3'd4;
        else if (c < 54 + s) return 3'd5;
        else                 return 3'd0;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [2:0] ph, input logic fon);
        exp_t e;
        e.tag   = tag;
        e.ph    = ph;
        e.lamps = exp_lamps(ph, fon);
        sb_q.push_back(e);
    endtask

    task automatic cycle_check();
        exp_t e;
        @(posedge clk);
        #1;
        check_cnt++;
        assert (sb_q.size() > 0) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL sb_empty: observed 0 entries expected 1");
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({e.tag, "_phase"}, {5'd0, phase}, {5'd0, e.ph});
            check({e.tag, "_lamps"},
                  {2'd0, a_red, a_yellow, a_green, b_red, b_yellow, b_green},
                  {2'd0, e.lamps});
        end
    endtask

    task automatic do_reset(input string tag);
        reset  = 1'b1;
        enable = 1'b1;
        flash  = 1'b0;
        req_b  = 1'b0;
        push(tag, 3'd5, 1'b0);
        cycle_check();
        check({tag, "_req_pend"}, {7'd0, dut.req_pend_r}, 8'd0);
        reset = 1'b0;
    endtask

    initial begin
        logic [2:0] ph;
        logic       fon;
        logic       ok;

        reset  = 1'b1;
        enable = 1'b1;
        flash  = 1'b0;
        req_b  = 1'b0;

        // No demand: A holds green indefinitely
        do_reset("idle_rst");
        for (int c = 1; c <= 201; c++) begin
            push("idle", (c < 2) ? 3'd5 : 3'd0, 1'b0);
            cycle_check();
        end

        // Single demand pulse, full cycle round to A
        do_reset("dem_rst");
        for (int c = 1; c <= 70; c++) begin
            req_b = (c - 1 == 5);
            push("dem", demand_phase(c, 0), 1'b0);
            cycle_check();
            check("dem_req_pend", {7'd0, dut.req_pend_r}, {7'd0, (c >= 6 && c < 28)});
        end
        req_b = 1'b0;

        // Enable low for cycles 30-39 stretches B green by ten cycles
        do_reset("stall_rst");
        for (int c = 1; c <= 80; c++) begin
            req_b  = (c - 1 == 5);
            enable = !((c - 1) >= 30 && (c - 1) <= 39);
            push("stall", demand_phase(c, 10), 1'b0);
            cycle_check();
        end
        req_b  = 1'b0;
        enable = 1'b1;

        // Flash held during B green, then a one-cycle flash pulse in A green
        do_reset("flash_rst");
        for (int c = 1; c <= 75; c++) begin
            req_b = (c - 1 == 5);
            flash = ((c - 1) >= 30 && (c - 1) <= 50) || (c - 1 == 60);
            fon   = 1'b0;
            if (c < 31)      ph = demand_phase(c, 0);
            else if (c < 52) begin
                ph  = 3'd6;
                fon = (((c - 31) / 8) % 2) == 0;
            end
            else if (c < 54) ph = 3'd5;
            else if (c < 61) ph = 3'd0;
            else if (c == 61) begin
                ph  = 3'd6;
                fon = 1'b1;
            end
            else if (c < 64) ph = 3'd5;
            else             ph = 3'd0;
            push("flash", ph, fon);
            cycle_check();
        end
        flash = 1'b0;
        req_b = 1'b0;

        // Reset pulse during A yellow drops demand and restarts via all-red
        do_reset("yrst_rst");
        for (int c = 1; c <= 30; c++) begin
            req_b = (c - 1 == 5);
            reset = (c - 1 == 23);
            if (c < 24)      ph = demand_phase(c, 0);
            else if (c < 26) ph = 3'd5;
            else             ph = 3'd0;
            push("yrst", ph, 1'b0);
            cycle_check();
            if (c == 23) check("yrst_pend_before", {7'd0, dut.req_pend_r}, 8'd1);
            if (c == 24) check("yrst_pend_after", {7'd0, dut.req_pend_r}, 8'd0);
        end
        reset = 1'b0;
        req_b = 1'b0;

        // Random enable/demand: lamp exclusivity and one lamp per approach
        for (int i = 0; i < 10000; i++) begin
            enable = ($urandom_range(0, 1) == 1);
            req_b  = ($urandom_range(0, 15) == 0);
            @(posedge clk);
            #1;
            ok = ((a_green | a_yellow) & (b_green | b_yellow)) == 1'b0
                 && $onehot({a_red, a_yellow, a_green})
                 && $onehot({b_red, b_yellow, b_green})
                 && (phase <= 3'd5);
            check("safety", {7'd0, ok}, 8'd1);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
